// File: rtl/strassen_sched.sv
// Microcoded sequencer for one 2x2 Strassen multiply on a shared single-ALU datapath.
// Walks a fixed 25-step program, driving ALU opcode, scratch addresses and write enable.
module strassen_sched #(
   parameter int MULT_LAT = 3,
   parameter int ADDR_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_alu_op,
   output logic [ADDR_W-1:0] o_rd_addr_a,
   output logic [ADDR_W-1:0] o_rd_addr_b,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_mem_we,
   output logic [4:0]        o_step,
   output logic [1:0]        o_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MULT = 3'd2;

   state_t      r_state;
   logic [4:0]  r_step;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;

   logic [17:0] w_entry;
   logic [2:0]  w_op;
   logic        w_exec;
   logic        w_last;

   // Program entry packing: {op[2:0], a[4:0], b[4:0], dst[4:0]}.
   function automatic logic [17:0] prog_entry(input logic [4:0] s);
      case (s)
         5'd0:    prog_entry = {OP_ADD,  5'd0,  5'd3,  5'd8};
         5'd1:    prog_entry = {OP_ADD,  5'd4,  5'd7,  5'd9};
         5'd2:    prog_entry = {OP_MULT, 5'd8,  5'd9,  5'd10};
         5'd3:    prog_entry = {OP_ADD,  5'd2,  5'd3,  5'd8};
         5'd4:    prog_entry = {OP_MULT, 5'd8,  5'd4,  5'd11};
         5'd5:    prog_entry = {OP_SUB,  5'd5,  5'd7,  5'd9};
         5'd6:    prog_entry = {OP_MULT, 5'd0,  5'd9,  5'd12};
         5'd7:    prog_entry = {OP_SUB,  5'd6,  5'd4,  5'd9};
         5'd8:    prog_entry = {OP_MULT, 5'd3,  5'd9,  5'd13};
         5'd9:    prog_entry = {OP_ADD,  5'd0,  5'd1,  5'd8};
         5'd10:   prog_entry = {OP_MULT, 5'd8,  5'd7,  5'd14};
         5'd11:   prog_entry = {OP_SUB,  5'd2,  5'd0,  5'd8};
         5'd12:   prog_entry = {OP_ADD,  5'd4,  5'd5,  5'd9};
         5'd13:   prog_entry = {OP_MULT, 5'd8,  5'd9,  5'd15};
         5'd14:   prog_entry = {OP_SUB,  5'd1,  5'd3,  5'd8};
         5'd15:   prog_entry = {OP_ADD,  5'd6,  5'd7,  5'd9};
         5'd16:   prog_entry = {OP_MULT, 5'd8,  5'd9,  5'd16};
         5'd17:   prog_entry = {OP_ADD,  5'd10, 5'd13, 5'd17};
         5'd18:   prog_entry = {OP_SUB,  5'd17, 5'd14, 5'd17};
         5'd19:   prog_entry = {OP_ADD,  5'd17, 5'd16, 5'd17};
         5'd20:   prog_entry = {OP_ADD,  5'd12, 5'd14, 5'd18};
         5'd21:   prog_entry = {OP_ADD,  5'd11, 5'd13, 5'd19};
         5'd22:   prog_entry = {OP_SUB,  5'd10, 5'd11, 5'd20};
         5'd23:   prog_entry = {OP_ADD,  5'd20, 5'd12, 5'd20};
         5'd24:   prog_entry = {OP_ADD,  5'd20, 5'd15, 5'd20};
         default: prog_entry = 18'd0;
      endcase
   endfunction

   assign w_entry = prog_entry(r_step);
   assign w_op    = w_entry[17:15];
   assign w_exec  = (r_state == S_EXEC);
   // Multiplies hold their controls for MULT_LAT cycles; everything else is single-cycle.
   assign w_last  = (w_op != OP_MULT) || (r_cnt == 4'(MULT_LAT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_step  <= 5'd0;
         r_cnt   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state <= S_EXEC;
                  r_busy  <= 1'b1;
                  r_step  <= 5'd0;
                  r_cnt   <= 4'd0;
               end
            end
            S_EXEC: begin
               if (w_last) begin
                  r_cnt <= 4'd0;
                  if (r_step == 5'd24) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_step <= r_step + 5'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_step      = r_step;
   assign o_state     = r_state;
   assign o_alu_op    = w_exec ? w_op : 3'd0;
   assign o_rd_addr_a = w_exec ? ADDR_W'(w_entry[14:10]) : '0;
   assign o_rd_addr_b = w_exec ? ADDR_W'(w_entry[9:5])   : '0;
   assign o_wr_addr   = w_exec ? ADDR_W'(w_entry[4:0])   : '0;
   assign o_mem_we    = w_exec && w_last;

endmodule

// File: doc/strassen_sched.md
# strassen_sched

Microcoded sequencer for one 2x2 Strassen matrix multiply on the shared single-ALU datapath. On `start`, it steps a fixed 25-entry program: seven products M1..M7, then the four C combinations. For each operation it drives the ALU opcode, two scratch-memory read addresses, the write address and `mem_we`, stretching multiplies to `MULT_LAT` cycles. It replaces the free-running step counter as the owner of the datapath controls.

## Interface
- `MULT_LAT`, default 3: cycles per multiply, legal range 1..15. Add and sub always take 1 cycle.
- `ADDR_W`, default 5: scratch-memory address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `busy`  out  1  high in EXEC and DONE.
- `done`  out  1  one-cycle completion pulse.
- `alu_op`  out  3  0 = ADD, 1 = SUB (a-b), 2 = MULT.
- `rd_addr_a`, `rd_addr_b`  out  ADDR_W  ALU operand a and b addresses.
- `wr_addr`  out  ADDR_W  result destination.
- `mem_we`  out  1  scratch write enable.
- `step`  out  5  current program index, for debug.

## Operation
- Address map:
  - A11..A22 = 0..3; B11..B22 = 4..7.
  - T0 = 8, T1 = 9; M1..M7 = 10..16.
  - C11 = 17, C12 = 18, C21 = 19, C22 = 20.
- Program, in the form "step: dst = a op b":
  - 0: T0 = A11+A22; 1: T1 = B11+B22; 2: M1 = T0*T1.
  - 3: T0 = A21+A22; 4: M2 = T0*B11.
  - 5: T1 = B12-B22; 6: M3 = A11*T1.
  - 7: T1 = B21-B11; 8: M4 = A22*T1.
  - 9: T0 = A11+A12; 10: M5 = T0*B22.
  - 11: T0 = A21-A11; 12: T1 = B11+B12; 13: M6 = T0*T1.
  - 14: T0 = A12-A22; 15: T1 = B21+B22; 16: M7 = T0*T1.
  - 17: C11 = M1+M4; 18: C11 = C11-M5; 19: C11 = C11+M7.
  - 20: C12 = M3+M5; 21: C21 = M2+M4.
  - 22: C22 = M1-M2; 23: C22 = C22+M3; 24: C22 = C22+M6.
- State machine: IDLE, EXEC, DONE.
  - IDLE -> EXEC when `start` = 1; `step` and the latency counter are cleared.
  - EXEC: the latency counter counts the cycles spent on the current step.
    - On the final cycle of a step, if `step` < 24: `step` increments and the counter clears.
    - On the final cycle of step 24: go to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Output decode (combinational from registered state):
  - In EXEC, `alu_op`, `rd_addr_a`, `rd_addr_b` and `wr_addr` come from the program entry for `step`. They are held constant for every cycle of that step.
  - `mem_we` = 1 only on the final cycle of the step, so there is exactly one write per step.
  - In IDLE and DONE, `alu_op`, all addresses and `mem_we` are 0.
- `start` in EXEC or DONE is ignored; no queuing.
- `start` held high through DONE does not relaunch from DONE. It launches again only after one cycle in IDLE.
- Reset values: state IDLE, `step` 0, counter 0, `busy` 0, `done` 0, `mem_we` 0, `alu_op` 0, all addresses 0.
- Asserting `rst_n` low mid-run aborts immediately. No further `mem_we` is issued; partial results in memory are left as is.

## Timing
- The rising edge that samples `start` in IDLE is edge E0. EXEC begins in the cycle after E0.
- Step duration: MULT_LAT cycles for steps 2, 4, 6, 8, 10, 13 and 16; 1 cycle for all others.
- EXEC length = 18 + 7*MULT_LAT cycles (39 at default).
- `done` = 1 in the cycle immediately after step 24's write. That is cycle 19 + 7*MULT_LAT after E0 (cycle 40 at default).
- Back-to-back runs: the earliest next launch edge is the IDLE cycle after DONE.
- Read-after-write hazard: the write of step n lands at the edge ending step n, and step n+1 reads it in the next cycle. The scratch memory must have synchronous write and combinational read.

## Test plan
- Reset, then `start` pulse at default MULT_LAT=3:
  - step 0 shows ADD, a=0, b=3, wr=8, `mem_we` = 1, for one cycle.
  - step 2 shows MULT, a=8, b=9, wr=10 for 3 cycles, with `mem_we` high only on the third.
  - `done` is high exactly in cycle 40; total `mem_we` pulses = 25.
- End to end: A = [1 2; 3 4], B = [5 6; 7 8], using a behavioural memory and ALU. After `done`, addresses 17..20 must hold 19, 22, 43, 50.
- MULT_LAT=1: `done` in cycle 26 after E0; `mem_we` is high on every EXEC cycle.
- `start` held high continuously: runs are separated by exactly one IDLE cycle. Mid-run `start` toggles do not change `step`.
- `rst_n` low at step 13, mid-multiply:
  - all outputs go to 0 asynchronously, with no write at the next edge;
  - after release, IDLE holds until `start`, and the next run begins again at step 0.
- Sequence check: every step's `alu_op`, `rd_addr_a`, `rd_addr_b` and `wr_addr` match the program table; SUB operand order is a-b, e.g. step 5 is a=5, b=7.
